reminder_alert: RTL and testbench

//  Consumer end of the timer's remind interface.
//  - Turns the timer's remind level into a user-facing alert: blinking LED, then solid LED plus buzzer.
//  - The alert clears on a button acknowledge or a detected drink; a snooze button defers it.
//  - Counts missed reminders for the VGA/status path.
//  - Sits between the timer (remind, stablizedWaterLevel) and board I/O (LEDs, buzzer, pushbuttons).
//

---
 rtl/alert_pkg.sv | 7 +
 rtl/reminder_alert_if.sv | 17 +
 rtl/btn_sync_edge.sv | 13 +
 rtl/reminder_alert.sv | 94 +++++++++
 tb/tb_reminder_alert.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/alert_pkg.sv
// alert_pkg: shared state encoding and default timing constants for reminder_alert
package alert_pkg;
   typedef enum logic [1:0] {IDLE, ALERT, SNOOZE, ESCALATE} alert_state_t;
   localparam int ACK_TIMEOUT_DEF  = 30;
   localparam int SNOOZE_TICKS_DEF = 10;
   localparam int DRINK_DELTA_DEF  = 2;
endpackage

// File: rtl/reminder_alert_if.sv
// reminder_alert_if: timer and board I/O bundle seen by the reminder alert block
interface reminder_alert_if #(parameter int MISS_W = 4);
   logic              tick;
   logic              remind;
   logic [3:0]        waterLevel;
   logic              ackBtn;
   logic              snoozeBtn;
   logic              alertLed;
   logic              buzzer;
   logic              alertActive;
   logic [MISS_W-1:0] missedCount;
   logic [1:0]        alertState;
   modport master (output tick, remind, waterLevel, ackBtn, snoozeBtn,
                   input alertLed, buzzer, alertActive, missedCount, alertState);
   modport slave (input tick, remind, waterLevel, ackBtn, snoozeBtn,
                  output alertLed, buzzer, alertActive, missedCount, alertState);
endinterface

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchronizer for a raw pushbutton followed by a rising-edge pulse
module btn_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);
   logic [2:0] sr;
   always_ff @(posedge clk or negedge reset)
      if (!reset) sr <= '0;
      else sr <= {sr[1:0], btn};
   assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/reminder_alert.sv
// reminder_alert: remind level -> blinking/solid alert with ack, snooze, drink clear and miss count.
// Define REMINDER_BUZZER_EN to drive an intermittent buzzer in ESCALATE; otherwise buzzer stays 0.
module reminder_alert
   import alert_pkg::*;
#(
   parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
   parameter int SNOOZE_TICKS = SNOOZE_TICKS_DEF,
   parameter int DRINK_DELTA  = DRINK_DELTA_DEF,
   parameter int MISS_W       = 4
) (
   input logic             clk,
   input logic             reset,
   reminder_alert_if.slave io
);
   localparam int CNT_W = $clog2((ACK_TIMEOUT > SNOOZE_TICKS ? ACK_TIMEOUT : SNOOZE_TICKS) + 1);
   alert_state_t      state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [3:0]        ref_lvl, ref_n;
   logic              blink, blink_n;
   logic [MISS_W-1:0] miss, miss_n;
   logic              rem_q, rem_edge, ack_edge, snz_edge, drink, miss_inc;
   btn_sync_edge u_ack (.clk(clk), .reset(reset), .btn(io.ackBtn), .pulse(ack_edge));
   btn_sync_edge u_snz (.clk(clk), .reset(reset), .btn(io.snoozeBtn), .pulse(snz_edge));
   assign rem_edge = io.remind & ~rem_q;
   // widened to 5 bits so level + delta never wraps
   assign drink = {1'b0, ref_lvl} >= ({1'b0, io.waterLevel} + 5'(DRINK_DELTA));
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      ref_n    = ref_lvl;
      blink_n  = blink;
      miss_inc = 1'b0;
      if (state == IDLE) begin
         if (rem_edge) begin
            state_n = ALERT;
            cnt_n   = '0;
            ref_n   = io.waterLevel;
            blink_n = 1'b0;
         end
      end else if (drink || (ack_edge && state != SNOOZE)) begin
         state_n = IDLE;
      end else if (rem_edge) begin
         miss_inc = 1'b1;
         state_n  = ALERT;
         cnt_n    = '0;
         ref_n    = io.waterLevel;
         blink_n  = 1'b0;
      end else if (state == ALERT && snz_edge) begin
         state_n = SNOOZE;
         cnt_n   = '0;
      end else if (io.tick) begin
         if (state == ALERT && cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            state_n  = ESCALATE;
            miss_inc = 1'b1;
         end else if (state == SNOOZE && cnt == CNT_W'(SNOOZE_TICKS - 1)) begin
            state_n = ALERT;
            cnt_n   = '0;
            blink_n = 1'b0;
         end else begin
            cnt_n   = state == ESCALATE ? cnt : cnt + 1'b1;
            blink_n = state == SNOOZE ? blink : ~blink;
         end
      end
      miss_n = (miss_inc && !(&miss)) ? miss + 1'b1 : miss;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         ref_lvl        <= '0;
         blink          <= 1'b0;
         miss           <= '0;
         rem_q          <= 1'b0;
         io.alertLed    <= 1'b0;
         io.buzzer      <= 1'b0;
         io.alertActive <= 1'b0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         ref_lvl        <= ref_n;
         blink          <= blink_n;
         miss           <= miss_n;
         rem_q          <= io.remind;
         io.alertLed    <= state_n == ALERT ? blink_n : state_n == ESCALATE;
         io.alertActive <= state_n == ALERT || state_n == ESCALATE;
`ifdef REMINDER_BUZZER_EN
         io.buzzer      <= (state_n == ESCALATE) & blink_n;
`else
         io.buzzer      <= 1'b0;
`endif
      end
   assign io.missedCount = miss;
   assign io.alertState  = state;
endmodule

// File: tb/tb_reminder_alert.sv
// tb_reminder_alert: directed vector table plus hand sequences for reminder_alert
module tb_reminder_alert;
   import alert_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   reminder_alert_if #(.MISS_W(2)) io ();
   reminder_alert #(.ACK_TIMEOUT(3), .SNOOZE_TICKS(2), .DRINK_DELTA(2), .MISS_W(2)) dut (
      .clk(clk), .reset(reset), .io(io)
   );
   typedef struct {
      logic       rem;
      logic [3:0] wl;
      logic       ack, snz, tick;
      logic [1:0] st;
      logic       act, led, buz;
      logic [1:0] miss;
   } vec_t;
   vec_t tbl[$];
   int checks = 0;
   int errors = 0;
   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask
   task automatic check_all(input string tag, input logic [1:0] st, input logic act, input logic led,
                            input logic buz, input logic [1:0] miss);
      logic eb;
`ifdef REMINDER_BUZZER_EN
      eb = buz;
`else
      eb = 1'b0;
`endif
      check({tag, " state"}, 8'(io.alertState), 8'(st));
      check({tag, " active"}, 8'(io.alertActive), 8'(act));
      check({tag, " led"}, 8'(io.alertLed), 8'(led));
      check({tag, " buzzer"}, 8'(io.buzzer), 8'(eb));
      check({tag, " missed"}, 8'(io.missedCount), 8'(miss));
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      // rem wl ack snz tick | st act led buz miss
      tbl.push_back('{0, 9, 0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{1, 9, 0, 0, 0, 1, 1, 0, 0, 0});
      tbl.push_back('{1, 9, 0, 0, 1, 1, 1, 1, 0, 0});
      tbl.push_back('{1, 9, 0, 0, 0, 1, 1, 1, 0, 0});
      tbl.push_back('{1, 9, 0, 0, 1, 1, 1, 0, 0, 0});
      tbl.push_back('{1, 9, 0, 0, 1, 3, 1, 1, 0, 1});
      tbl.push_back('{1, 9, 0, 0, 1, 3, 1, 1, 1, 1});
      tbl.push_back('{1, 7, 0, 0, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{0, 9, 0, 0, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{1, 9, 0, 0, 0, 1, 1, 0, 0, 1});
      tbl.push_back('{1, 8, 0, 0, 0, 1, 1, 0, 0, 1});
      tbl.push_back('{1, 7, 0, 0, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{0, 7, 0, 0, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{1, 7, 0, 0, 0, 1, 1, 0, 0, 1});
      tbl.push_back('{1, 7, 1, 0, 0, 1, 1, 0, 0, 1});
      tbl.push_back('{1, 7, 1, 0, 0, 1, 1, 0, 0, 1});
      tbl.push_back('{1, 7, 1, 0, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{1, 7, 1, 0, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{1, 7, 0, 0, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{0, 7, 0, 0, 0, 0, 0, 0, 0, 1});
      tbl.push_back('{1, 7, 0, 0, 0, 1, 1, 0, 0, 1});
      tbl.push_back('{1, 7, 0, 0, 1, 1, 1, 1, 0, 1});
      tbl.push_back('{1, 7, 0, 1, 0, 1, 1, 1, 0, 1});
      tbl.push_back('{1, 7, 0, 1, 0, 1, 1, 1, 0, 1});
      tbl.push_back('{1, 7, 0, 1, 0, 2, 0, 0, 0, 1});
      tbl.push_back('{1, 7, 0, 0, 1, 2, 0, 0, 0, 1});
      tbl.push_back('{1, 7, 0, 0, 1, 1, 1, 0, 0, 1});
      tbl.push_back('{1, 7, 0, 0, 1, 1, 1, 1, 0, 1});
      tbl.push_back('{1, 7, 0, 0, 1, 1, 1, 0, 0, 1});
      tbl.push_back('{1, 7, 0, 0, 1, 3, 1, 1, 0, 2});
      tbl.push_back('{0, 7, 1, 0, 0, 3, 1, 1, 0, 2});
      tbl.push_back('{0, 7, 1, 0, 0, 3, 1, 1, 0, 2});
      tbl.push_back('{1, 7, 1, 0, 0, 0, 0, 0, 0, 2});
      tbl.push_back('{0, 7, 0, 0, 0, 0, 0, 0, 0, 2});
      tbl.push_back('{1, 7, 0, 0, 0, 1, 1, 0, 0, 2});
      tbl.push_back('{1, 7, 0, 0, 1, 1, 1, 1, 0, 2});
      tbl.push_back('{1, 7, 0, 0, 1, 1, 1, 0, 0, 2});
      tbl.push_back('{1, 7, 0, 0, 1, 3, 1, 1, 0, 3});
      tbl.push_back('{0, 7, 0, 0, 0, 3, 1, 1, 0, 3});
      tbl.push_back('{1, 7, 0, 0, 0, 1, 1, 0, 0, 3});
      tbl.push_back('{1, 7, 0, 0, 1, 1, 1, 1, 0, 3});
      tbl.push_back('{1, 7, 0, 0, 1, 1, 1, 0, 0, 3});
      tbl.push_back('{1, 7, 0, 0, 1, 3, 1, 1, 0, 3});
      tbl.push_back('{0, 7, 0, 0, 0, 3, 1, 1, 0, 3});
      io.tick = 1'b0;
      io.remind = 1'b0;
      io.waterLevel = 4'd9;
      io.ackBtn = 1'b0;
      io.snoozeBtn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      reset = 1'b1;
      foreach (tbl[i]) begin
         io.remind = tbl[i].rem;
         io.waterLevel = tbl[i].wl;
         io.ackBtn = tbl[i].ack;
         io.snoozeBtn = tbl[i].snz;
         io.tick = tbl[i].tick;
         step();
         check_all($sformatf("v%0d", i), tbl[i].st, tbl[i].act, tbl[i].led, tbl[i].buz, tbl[i].miss);
      end
      // bouncing ack: glitches between clock edges must yield a single edge
      io.remind = 1'b1;
      step();
      check_all("bounce entry", 2'd1, 1'b1, 1'b0, 1'b0, 2'd3);
      io.ackBtn = 1'b1;
      #2 io.ackBtn = 1'b0;
      #1 io.ackBtn = 1'b1;
      #1 io.ackBtn = 1'b0;
      #1 io.ackBtn = 1'b1;
      step();
      step();
      check("bounce hold", 8'(io.alertState), 8'(ALERT));
      step();
      check("bounce clear", 8'(io.alertState), 8'(IDLE));
      io.remind = 1'b0;
      step();
      io.remind = 1'b1;
      step();
      check("rearm alert", 8'(io.alertState), 8'(ALERT));
      for (int k = 0; k < 3; k++) begin
         #2 io.ackBtn = 1'b0;
         #1 io.ackBtn = 1'b1;
         step();
         check($sformatf("no second edge %0d", k), 8'(io.alertState), 8'(ALERT));
      end
      io.ackBtn = 1'b0;
      // snooze is ignored once escalated
      io.tick = 1'b1;
      repeat (3) step();
      io.tick = 1'b0;
      check("escalate again", 8'(io.alertState), 8'(ESCALATE));
      io.snoozeBtn = 1'b1;
      repeat (4) step();
      check("snooze ignored", 8'(io.alertState), 8'(ESCALATE));
      io.snoozeBtn = 1'b0;
      // asynchronous reset in the middle of ALERT
      io.remind = 1'b0;
      step();
      io.remind = 1'b1;
      step();
      io.tick = 1'b1;
      step();
      io.tick = 1'b0;
      check_all("pre reset", 2'd1, 1'b1, 1'b1, 1'b0, 2'd3);
      reset = 1'b0;
      #1;
      check_all("async reset", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      step();
      check_all("reset held", 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
      reset = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
